// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round helper functions and the skid-buffer state
// encoding used by every unrolled compression stage.
package sha256_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_logic.sv
// One SHA-256 compression round, purely combinational; the round constant is
// an input so the same block serves all 64 unrolled stages.
module sha256_round_logic
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  w_in,
    input  logic [31:0]  k,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w_in;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_round_pipeline_stage.sv
// Compression-round pipeline stage: round result registered behind a 2-entry
// skid buffer so chained stages sustain one result per cycle.
module sha256_round_pipeline_stage
    import sha256_pkg::*;
#(
    parameter int ROUND = 60,
    parameter int TAG_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     state_in,
    input  logic [31:0]      w_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     state_out,
    output logic [TAG_W-1:0] tag_out
);

    localparam logic [31:0] K_ROUND = K[ROUND];

    buf_state_t       buf_state;
    logic [255:0]     round_result;
    logic [255:0]     skid_state;
    logic [TAG_W-1:0] skid_tag;
    logic             accept;
    logic             emit;

    sha256_round_logic u_round (
        .state_in  (state_in),
        .w_in      (w_in),
        .k         (K_ROUND),
        .state_out (round_result)
    );

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // state_out/tag_out are the main register; in_ready/out_valid track the
    // FSM state as flops so out_ready never reaches in_ready combinationally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_state  <= EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            state_out  <= '0;
            tag_out    <= '0;
            skid_state <= '0;
            skid_tag   <= '0;
        end else begin
            case (buf_state)
                EMPTY: begin
                    if (accept) begin
                        state_out <= round_result;
                        tag_out   <= tag_in;
                        buf_state <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        state_out <= round_result;
                        tag_out   <= tag_in;
                    end else if (accept) begin
                        skid_state <= round_result;
                        skid_tag   <= tag_in;
                        buf_state  <= FULL;
                        in_ready   <= 1'b0;
                    end else if (emit) begin
                        buf_state <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_out <= skid_state;
                        tag_out   <= skid_tag;
                        buf_state <= ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    buf_state <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_pipeline_stage.sv
// Scoreboard bench for the round stage (ROUND=0): directed known-answer,
// streaming, backpressure and reset cases, then random valid/ready traffic.
module tb_sha256_round_pipeline_stage;

    localparam int TAG_W = 32;
    localparam logic [31:0] K0 = 32'h428a2f98;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [255:0]     state_in = '0;
    logic [31:0]      w_in = '0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [255:0]     state_out;
    logic [TAG_W-1:0] tag_out;

    int tests = 0;
    int fails = 0;

    logic [255:0]     exp_state_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    int               pushed = 0;
    int               popped = 0;

    always #5 CLK = ~CLK;

    sha256_round_pipeline_stage #(.ROUND(0), .TAG_W(TAG_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .w_in      (w_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .tag_out   (tag_out)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference round straight from the textbook definitions over a word array.
    function automatic logic [255:0] ref_round(input logic [255:0] s, input logic [31:0] w);
        logic [31:0] v[8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 8; i++) v[i] = s[255 - 32*i -: 32];
        t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K0 + w;
        t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        return {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Drive one cycle's inputs at the falling edge; an offer seen with in_ready
    // high will be taken at the next rising edge, so its expectation is queued.
    task automatic cycle(input logic v, input logic [255:0] s, input logic [31:0] w,
                         input logic [TAG_W-1:0] t, input logic ordy, output logic acc);
        @(negedge CLK);
        in_valid  = v;
        state_in  = s;
        w_in      = w;
        tag_in    = t;
        out_ready = ordy;
        acc = v && in_ready && !RST;
        if (acc) begin
            exp_state_q.push_back(ref_round(s, w));
            exp_tag_q.push_back(t);
            pushed++;
        end
    endtask

    // Monitor: pops on every emit and checks data is held while stalled.
    logic             held_pending = 1'b0;
    logic [255:0]     held_state;
    logic [TAG_W-1:0] held_tag;

    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (!RST && out_valid) begin
                if (held_pending) begin
                    check("hold_state", state_out, held_state);
                    check("hold_tag", 256'(tag_out), 256'(held_tag));
                end
                if (out_ready) begin
                    held_pending = 1'b0;
                    if (exp_state_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got tag %h required no output", tag_out);
                    end else begin
                        check("out_state", state_out, exp_state_q.pop_front());
                        check("out_tag", 256'(tag_out), 256'(exp_tag_q.pop_front()));
                        popped++;
                    end
                end else begin
                    held_pending = 1'b1;
                    held_state   = state_out;
                    held_tag     = tag_out;
                end
            end else begin
                held_pending = 1'b0;
            end
        end
    end

    logic [255:0] iv_state;
    logic [255:0] ps;
    logic [31:0]  pw;
    logic [TAG_W-1:0] pt;
    logic         acc;
    logic         pending;
    int           issued;
    int           cyc;

    initial begin
        iv_state = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

        // Reset state
        #12;
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_in_ready", 256'(in_ready), 256'(1'b1));
        check("rst_state_out", state_out, 256'd0);
        check("rst_tag_out", 256'(tag_out), 256'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Known answer: round 0 of "abc"
        cycle(1'b1, iv_state, 32'h61626380, 32'h100, 1'b1, acc);
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        #1;
        check("kat_valid", 256'(out_valid), 256'(1'b1));
        check("kat_state", state_out,
              {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
               32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab});
        cycle(1'b0, '0, '0, '0, 1'b1, acc);

        // Streaming: 8 back-to-back, outputs on consecutive cycles
        for (int i = 0; i < 9; i++) begin
            cycle(i < 8, rand256(), $urandom, TAG_W'(i), 1'b1, acc);
            #1;
            if (i > 0) check("stream_valid", 256'(out_valid), 256'(1'b1));
        end
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        #1;
        check("stream_drained", 256'(out_valid), 256'(1'b0));

        // Backpressure: 3 offered, 2 taken, then release in order
        ps = rand256(); pw = $urandom;
        cycle(1'b1, ps, pw, 32'd0, 1'b0, acc);
        ps = rand256(); pw = $urandom;
        cycle(1'b1, ps, pw, 32'd1, 1'b0, acc);
        #1;
        check("bp_ready_one", 256'(in_ready), 256'(1'b1));
        check("bp_valid_one", 256'(out_valid), 256'(1'b1));
        ps = rand256(); pw = $urandom;
        cycle(1'b1, ps, pw, 32'd2, 1'b0, acc);
        #1;
        check("bp_ready_full", 256'(in_ready), 256'(1'b0));
        check("bp_tag_held", 256'(tag_out), 256'd0);
        cycle(1'b1, ps, pw, 32'd2, 1'b0, acc);
        #1;
        check("bp_ready_full2", 256'(in_ready), 256'(1'b0));
        cycle(1'b1, ps, pw, 32'd2, 1'b1, acc);
        cycle(1'b1, ps, pw, 32'd2, 1'b1, acc);
        #1;
        check("bp_tag1", 256'(tag_out), 256'd1);
        check("bp_take_third", 256'(acc), 256'(1'b1));
        // previous cycle accepted and emitted together from ONE
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        #1;
        check("ae_tag2", 256'(tag_out), 256'd2);
        check("ae_ready", 256'(in_ready), 256'(1'b1));
        check("ae_valid", 256'(out_valid), 256'(1'b1));
        cycle(1'b0, '0, '0, '0, 1'b1, acc);

        // Reset while FULL, asserted mid-cycle
        cycle(1'b1, rand256(), $urandom, 32'h55, 1'b0, acc);
        cycle(1'b1, rand256(), $urandom, 32'h56, 1'b0, acc);
        cycle(1'b0, '0, '0, '0, 1'b0, acc);
        #3;
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 256'(out_valid), 256'(1'b0));
        check("mid_rst_ready", 256'(in_ready), 256'(1'b1));
        check("mid_rst_state", state_out, 256'd0);
        exp_state_q.delete();
        exp_tag_q.delete();
        popped = pushed;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b1, rand256(), $urandom, 32'h77, 1'b1, acc);
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        #1;
        check("post_rst_tag", 256'(tag_out), 256'h77);
        cycle(1'b0, '0, '0, '0, 1'b1, acc);

        // Random valid/ready traffic; upstream holds an offer until taken
        issued = 0;
        cyc = 0;
        pending = 1'b0;
        while ((issued < 10000 || exp_state_q.size() > 0 || pending) && cyc < 60000) begin
            if (!pending && issued < 10000 && $urandom_range(0, 3) != 0) begin
                ps = rand256(); pw = $urandom; pt = $urandom;
                pending = 1'b1;
            end
            cycle(pending, ps, pw, pt, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                pending = 1'b0;
                issued++;
            end
            cyc++;
        end
        if (cyc >= 60000) begin
            tests++;
            fails++;
            $display("FAIL random_timeout: got %0d issued required 10000", issued);
        end
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        check("no_loss", 256'(popped), 256'(pushed));
        check("queue_empty", 256'(exp_state_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
